// File: rtl/axis_fir_mc.sv
// -----------------------------------------------------------------------------
// axis_fir_mc
// Multi-channel AXI4-Stream FIR filter. The input is a time-interleaved stream
// of NUM_CHANNELS channels; each channel owns its own delay line. All channels
// share one compile-time coefficient set. Results are rounded (half up) and
// shifted by OUT_SHIFT, then saturated to DATA_WIDTH. TLAST marks the last
// channel of each frame. A TLAST that disagrees with the channel count sets a
// sticky frame_err.
//
// Ports
//   ACLK           clock, rising edge
//   ARESET         asynchronous active-high reset
//   s_axis_*       slave stream: tdata, tvalid, tready, tlast
//   m_axis_*       master stream: tdata, tvalid, tready, tlast, tuser (channel)
//   frame_err      sticky TLAST/channel-count mismatch flag
// -----------------------------------------------------------------------------
module axis_fir_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int COEF_WIDTH   = 16,
    parameter int NUM_TAPS     = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int OUT_SHIFT    = 0,
    parameter logic [NUM_TAPS*COEF_WIDTH-1:0] COEFS = '0,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CW-1:0]         m_axis_tuser,
    output logic                  frame_err
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int AW = PW + $clog2(NUM_TAPS);
    // One extra bit so the rounding bias can never wrap the accumulator.
    localparam int RW = AW + 1;
    localparam longint RND = (OUT_SHIFT > 0)
        ? (longint'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : longint'(0);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((longint'(1) << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(longint'(1) << (DATA_WIDTH - 1)));
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

    logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] sample;
    // Per-channel history; index 0 is the previous sample of that channel.
    logic signed [DATA_WIDTH-1:0] dline [NUM_CHANNELS][NUM_TAPS-1];
    logic [CW-1:0]                ch_cnt;
    logic                         adv;
    logic                         accept;
    logic                         last_exp;

    logic signed [PW-1:0] prod_next [NUM_TAPS];
    logic signed [PW-1:0] prod      [NUM_TAPS];
    logic                 p1_valid;
    logic [CW-1:0]        p1_ch;

    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] acc;
    logic                 p2_valid;
    logic [CW-1:0]        p2_ch;

    logic signed [RW-1:0]         rnd;
    logic signed [DATA_WIDTH-1:0] sat;

    // All three stages move together; the output register frees up either
    // when it is empty or when its beat is being taken this cycle.
    assign adv           = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = adv;
    assign accept        = s_axis_tvalid && adv;
    assign last_exp      = (ch_cnt == LAST_CH);
    assign sample        = s_axis_tdata;

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef[k] = COEFS[k*COEF_WIDTH +: COEF_WIDTH];
        end
    end

    // Tap 0 is the incoming sample; taps 1..N-1 come from the channel's line.
    always_comb begin
        prod_next[0] = PW'(sample) * PW'(coef[0]);
        for (int k = 1; k < NUM_TAPS; k++) begin
            prod_next[k] = PW'(dline[ch_cnt][k-1]) * PW'(coef[k]);
        end
    end

    always_comb begin
        acc_next = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc_next = acc_next + AW'(prod[k]);
        end
    end

    always_comb begin
        rnd = (RW'(acc) + RW'(RND)) >>> OUT_SHIFT;
        if (rnd > SAT_MAX) begin
            sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (rnd < SAT_MIN) begin
            sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat = rnd[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int k = 0; k < NUM_TAPS - 1; k++) begin
                    dline[c][k] <= '0;
                end
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod[k] <= '0;
            end
            ch_cnt        <= '0;
            frame_err     <= 1'b0;
            p1_valid      <= 1'b0;
            p1_ch         <= '0;
            acc           <= '0;
            p2_valid      <= 1'b0;
            p2_ch         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else begin
            if (accept) begin
                for (int k = NUM_TAPS - 2; k > 0; k--) begin
                    dline[ch_cnt][k] <= dline[ch_cnt][k-1];
                end
                dline[ch_cnt][0] <= sample;
                if (s_axis_tlast != last_exp) begin
                    frame_err <= 1'b1;
                end
                // An early TLAST resynchronises the channel count to the frame.
                if (s_axis_tlast || last_exp) begin
                    ch_cnt <= '0;
                end else begin
                    ch_cnt <= ch_cnt + CW'(1);
                end
            end
            if (adv) begin
                p1_valid <= s_axis_tvalid;
                if (accept) begin
                    prod  <= prod_next;
                    p1_ch <= ch_cnt;
                end
                p2_valid <= p1_valid;
                if (p1_valid) begin
                    acc   <= acc_next;
                    p2_ch <= p1_ch;
                end
                m_axis_tvalid <= p2_valid;
                if (p2_valid) begin
                    m_axis_tdata <= sat;
                    m_axis_tuser <= p2_ch;
                    m_axis_tlast <= (p2_ch == LAST_CH);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_fir_mc.sv
// -----------------------------------------------------------------------------
// tb_axis_fir_mc
// Two filter instances share one input stream and one m_axis_tready:
//   dut_a: COEFS 1..8, OUT_SHIFT 0   (impulse, isolation, framing)
//   dut_b: tap0 8192, taps1..7 16384, OUT_SHIFT 14 (rounding, saturation)
// Every accepted beat is fed to a reference model that keeps a per-channel
// sample history and computes the dot product with plain integer arithmetic.
// Every output handshake is compared against that model.
// -----------------------------------------------------------------------------
module tb_axis_fir_mc;

    localparam int NT = 8;
    localparam int NC = 2;
    localparam logic [NT*16-1:0] COEFS_A =
        {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [NT*16-1:0] COEFS_B =
        {16'd16384, 16'd16384, 16'd16384, 16'd16384,
         16'd16384, 16'd16384, 16'd16384, 16'd8192};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b1;

    logic        s_tready_a, s_tready_b;
    logic [15:0] m_tdata_a, m_tdata_b;
    logic        m_tvalid_a, m_tvalid_b;
    logic        m_tlast_a, m_tlast_b;
    logic [0:0]  m_tuser_a, m_tuser_b;
    logic        ferr_a, ferr_b;

    always #5 clk = ~clk;

    axis_fir_mc #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(NT), .NUM_CHANNELS(NC),
        .OUT_SHIFT(0), .COEFS(COEFS_A)
    ) dut_a (
        .ACLK(clk), .ARESET(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready_a), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_a),
        .m_axis_tuser(m_tuser_a), .frame_err(ferr_a)
    );

    axis_fir_mc #(
        .DATA_WIDTH(16), .COEF_WIDTH(16), .NUM_TAPS(NT), .NUM_CHANNELS(NC),
        .OUT_SHIFT(14), .COEFS(COEFS_B)
    ) dut_b (
        .ACLK(clk), .ARESET(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready_b), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_b),
        .m_axis_tuser(m_tuser_b), .frame_err(ferr_b)
    );

    // ---------------- reference model ----------------
    typedef struct { int a; int b; int ch; int last; } exp_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic [0:0] ch; logic last; } obs_t;

    int   coef_a [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int   coef_b [8] = '{8192, 16384, 16384, 16384, 16384, 16384, 16384, 16384};
    int   hist [NC][8];
    int   mch;
    bit   merr;
    exp_t exp_q [$];
    obs_t cap [$];

    int checks = 0;
    int errors = 0;
    int ready_pct = 100;

    bit          prev_stall;
    logic [15:0] hold_a, hold_b;
    logic [0:0]  hold_u;
    logic        hold_l;
    exp_t        mon_e;
    obs_t        mon_o;

    function automatic int filt(input int h[8], input int co[8], input int sh);
        longint s = 0;
        for (int k = 0; k < 8; k++) s += longint'(h[k]) * longint'(co[k]);
        // round half up: floor((s + 2^(sh-1)) / 2^sh)
        if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < 8; k++) hist[c][k] = 0;
        mch  = 0;
        merr = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [15:0] d, input logic l);
        int   c = mch;
        int   row [8];
        exp_t e;
        for (int k = 7; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = int'($signed(d));
        for (int k = 0; k < 8; k++) row[k] = hist[c][k];
        e.a    = filt(row, coef_a, 0);
        e.b    = filt(row, coef_b, 14);
        e.ch   = c;
        e.last = (c == NC - 1) ? 1 : 0;
        exp_q.push_back(e);
        if (l != (c == NC - 1)) merr = 1'b1;
        mch = (l || c == NC - 1) ? 0 : c + 1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", m_tvalid_a, 1);
                chk("hold_data_a", $signed(m_tdata_a), $signed(hold_a));
                chk("hold_data_b", $signed(m_tdata_b), $signed(hold_b));
                chk("hold_user", m_tuser_a, hold_u);
                chk("hold_last", m_tlast_a, hold_l);
            end
            chk("frame_err_a", ferr_a, merr);
            chk("frame_err_b", ferr_b, merr);
            if (m_tvalid_a && m_tready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_output observed=%0d expected=none", $signed(m_tdata_a));
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_data_a", $signed(m_tdata_a), mon_e.a);
                    chk("out_data_b", $signed(m_tdata_b), mon_e.b);
                    chk("out_valid_b", m_tvalid_b, 1);
                    chk("out_user", m_tuser_a, mon_e.ch);
                    chk("out_last", m_tlast_a, mon_e.last);
                end
                mon_o.a = m_tdata_a; mon_o.b = m_tdata_b;
                mon_o.ch = m_tuser_a; mon_o.last = m_tlast_a;
                cap.push_back(mon_o);
            end
            prev_stall = m_tvalid_a && !m_tready;
            hold_a = m_tdata_a; hold_b = m_tdata_b;
            hold_u = m_tuser_a; hold_l = m_tlast_a;
            if (s_tvalid && s_tready_a) model_accept(s_tdata, s_tlast);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        m_tready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < ready_pct);
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        bit done = 1'b0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        while (!done && n < 500) begin
            @(negedge clk);
            done = s_tready_a;
            tick();
            n++;
        end
        s_tvalid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n = 0;
        ready_pct = 100; m_tready = 1'b1; s_tvalid = 1'b0;
        while ((exp_q.size() != 0 || m_tvalid_a) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic impulse_check(input string tag);
        chk({tag, "_count"}, cap.size(), 20);
        if (cap.size() >= 20) begin
            for (int i = 0; i < 10; i++) begin
                chk({tag, "_ch0_a"}, $signed(cap[2*i].a), (i < 8) ? i + 1 : 0);
                chk({tag, "_ch1_a"}, $signed(cap[2*i+1].a), 0);
                chk({tag, "_ch0_b"}, $signed(cap[2*i].b), (i < 8) ? 1 : 0);
                chk({tag, "_user0"}, cap[2*i].ch, 0);
                chk({tag, "_user1"}, cap[2*i+1].ch, 1);
                chk({tag, "_last0"}, cap[2*i].last, 0);
                chk({tag, "_last1"}, cap[2*i+1].last, 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int r;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid_a, 0);
        chk("rst_tdata", m_tdata_a, 0);
        chk("rst_tlast", m_tlast_a, 0);
        chk("rst_tuser", m_tuser_a, 0);
        chk("rst_ferr", ferr_a, 0);
        chk("rst_tvalid_b", m_tvalid_b, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", s_tready_a, 1);

        // latency: accepted at edge N, valid after edge N+2
        s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        chk("lat_n", m_tvalid_a, 0);
        tick();
        chk("lat_n1", m_tvalid_a, 0);
        tick();
        chk("lat_n2", m_tvalid_a, 1);
        send(16'd0, 1'b1);
        drain();

        // impulse on ch0, ch1 silent
        cap.delete();
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'd1 : 16'd0, 1'b0);
            send(16'd0, 1'b1);
        end
        drain();
        impulse_check("imp");

        // channel isolation
        cap.delete();
        for (int i = 0; i < 12; i++) begin
            send(16'd100, 1'b0);
            send(16'hFFFD, 1'b1);
        end
        drain();
        chk("iso_count", cap.size(), 24);
        if (cap.size() >= 24) begin
            for (int i = 0; i < 12; i++) begin
                r = (i < 8) ? (i + 1) * (i + 2) / 2 : 36;
                chk("iso_ch0", $signed(cap[2*i].a), 100 * r);
                chk("iso_ch1", $signed(cap[2*i+1].a), -3 * r);
            end
            chk("iso_ch0_b", $signed(cap[22].b), 750);
            chk("iso_ch1_b_round", $signed(cap[23].b), -22);
        end

        // saturation
        cap.delete();
        for (int i = 0; i < 10; i++) begin
            send(16'd32767, 1'b0);
            send(16'h8000, 1'b1);
        end
        drain();
        chk("sat_count", cap.size(), 20);
        if (cap.size() >= 20) begin
            chk("sat_pos_a", $signed(cap[18].a), 32767);
            chk("sat_neg_a", $signed(cap[19].a), -32768);
            chk("sat_pos_b", $signed(cap[18].b), 32767);
            chk("sat_neg_b", $signed(cap[19].b), -32768);
        end

        // framing error: TLAST on a ch0 beat
        chk("ferr_before", ferr_a, 0);
        cap.delete();
        send(16'd5, 1'b1);
        chk("ferr_set", ferr_a, 1);
        send(16'd7, 1'b0);
        send(16'd9, 1'b1);
        chk("ferr_no_stall", s_tready_a, 1);
        drain();
        chk("ferr_count", cap.size(), 3);
        if (cap.size() >= 3) begin
            chk("ferr_user0", cap[0].ch, 0);
            chk("ferr_user1", cap[1].ch, 0);
            chk("ferr_user2", cap[2].ch, 1);
            chk("ferr_last0", cap[0].last, 0);
            chk("ferr_last2", cap[2].last, 1);
        end
        chk("ferr_sticky", ferr_a, 1);

        // backpressure soak
        cap.delete();
        ready_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 30) idle(int'($urandom_range(1, 3)));
            send(16'($urandom), (i % 2) == 1);
        end
        drain();
        chk("soak_count", cap.size(), 2000);

        // reset with three beats in flight
        ready_pct = 0;
        m_tready = 1'b0;
        send(16'd11, 1'b0);
        send(16'd12, 1'b1);
        send(16'd13, 1'b0);
        chk("stall_ready", s_tready_a, 0);
        chk("stall_valid", m_tvalid_a, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", m_tvalid_a, 0);
        chk("mid_rst_tdata", m_tdata_a, 0);
        chk("mid_rst_ferr", ferr_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_pct = 100;
        m_tready = 1'b1;
        cap.delete();
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'd1 : 16'd0, 1'b0);
            send(16'd0, 1'b1);
        end
        drain();
        impulse_check("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_fir_mc.md
# axis_fir_mc

Parametrised multi-channel AXI4-Stream FIR filter, successor to the single-channel `axis_fir`. It accepts a time-interleaved stream of NUM_CHANNELS channels and keeps an independent delay line per channel. It applies one shared compile-time coefficient set and emits rounded, saturated results on a fully backpressurable AXI4-Stream master. Channel framing is carried by TLAST, and framing violations are flagged.

## Interface
Parameters:
- DATA_WIDTH, 16: input/output sample width, signed two's complement.
- COEF_WIDTH, 16: coefficient width, signed.
- NUM_TAPS, 8: taps per channel, ≥ 2.
- NUM_CHANNELS, 2: interleaved channels, ≥ 1.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- COEFS, all-zero: packed NUM_TAPS×COEF_WIDTH vector; slice k (LSB-first) multiplies the sample k beats old in that channel (k=0 is newest).

Ports (CW = max(1, clog2(NUM_CHANNELS))):
- ACLK  in  1  clock. All logic is on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  marks the beat for channel NUM_CHANNELS-1.
- m_axis_tdata  out  DATA_WIDTH  filtered sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on outputs for channel NUM_CHANNELS-1.
- m_axis_tuser  out  CW  channel index of the output beat.
- frame_err  out  1  sticky TLAST/channel-count mismatch flag.

## Operation
- Input channel counter ch_cnt starts at 0 and increments on every accepted beat. It wraps to 0 after NUM_CHANNELS-1.
- Accepted beat: the sample is shifted into delay line[ch_cnt] only; every other channel's line is untouched.
- TLAST check, applied on each accepted beat:
  - expected = (ch_cnt == NUM_CHANNELS-1).
  - If s_axis_tlast ≠ expected, set frame_err (it stays set until reset).
  - If s_axis_tlast=1, ch_cnt resyncs to 0 regardless of its value.
- Pipeline has three stages, all sharing one advance enable adv = !m_axis_tvalid || m_axis_tready:
  - P1 (accept edge): register NUM_TAPS products of {new sample, line[ch] taps 0..N-2} × COEFS. Capture ch and valid.
  - P2: sum the products into accumulator width DATA_WIDTH+COEF_WIDTH+clog2(NUM_TAPS).
  - P3: round, shift and saturate into the output register. Drive tvalid, tuser=ch and tlast=(ch==NUM_CHANNELS-1).
- Rounding when OUT_SHIFT>0: add 2^(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT (round half up). When OUT_SHIFT=0, no rounding is applied.
- Saturation: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- s_axis_tready = adv. A beat is accepted only when s_axis_tvalid && adv.
- Bubbles (invalid beats) propagate through the stages and do not alter the delay lines or ch_cnt.
- No beat is dropped or duplicated. Output order equals input order.

## Timing
- Reset (asynchronous assert, synchronous release to logic) sets:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, frame_err=0.
  - s_axis_tready=1 from the first edge after release.
  - All delay lines 0, ch_cnt=0, all stage valids 0.
- Latency: a beat accepted at edge N makes m_axis_tvalid high after edge N+2 when not stalled. Throughput is one beat per cycle.
- Stall: while m_axis_tvalid=1 and m_axis_tready=0, all stages hold and s_axis_tready=0. The output register holds tdata/tlast/tuser stable until the handshake.
- Same-cycle output handshake and input accept is legal; it sustains full rate.
- The ready path is combinational from m_axis_tready to s_axis_tready. No combinational path exists from s_axis_tvalid to any output.
- ARESET mid-stream: all in-flight beats are discarded and the delay lines are zeroed immediately. The first post-reset beat is treated as channel 0.
- NUM_CHANNELS=1: ch_cnt is constant 0, m_axis_tuser=0, m_axis_tlast=1 on every output, and every input beat is expected to carry TLAST=1.

## Test plan
- Impulse per channel (NUM_TAPS=8, NUM_CHANNELS=2, COEFS=1..8 for taps 0..7, OUT_SHIFT=0):
  - Stimulus: ch0 sample 1 followed by zeros, ch1 all zeros, TLAST on every ch1 beat.
  - Required: ch0 outputs 1,2,…,8,0,0. All ch1 outputs are 0. tuser alternates 0,1. tlast is high on ch1 only.
- Channel isolation:
  - Stimulus: ch0 constant 100, ch1 constant -3.
  - Required: steady state ch0=3600, ch1=-108, with no cross-talk during the ramp.
- Backpressure soak: 2000 beats with random s_axis_tvalid and random m_axis_tready.
  - Required: output sequence equals the reference model beat-for-beat.
  - Required: tdata/tlast/tuser stay stable while tvalid && !tready. No loss or duplication.
- Saturation and rounding (all COEFS=16384, OUT_SHIFT=14):
  - Stimulus: input 32767 steady. Required: output 32767 (saturated).
  - Stimulus: input -32768 steady. Required: output -32768.
  - Stimulus: single taps-sum case with input 1, COEF 8192. Required: result rounds to 1 (half up).
- Framing error:
  - Stimulus: TLAST on a ch0 beat.
  - Required: frame_err rises after that edge and stays set. The next beat is treated as ch0. Outputs continue without stall.
- Reset mid-stream: assert ARESET for 2 cycles with 3 beats in flight.
  - Required: m_axis_tvalid is 0 immediately. The first post-reset impulse on ch0 reproduces 1..8 with no residue from the old history.
